// File: rtl/harness_sequencer.sv
// harness_sequencer
//   Command sequencer for the delay-line test harness. Decodes opcode bytes
//   from the UART receiver, programs the delay-line length, opens a counted
//   run window (run / out_en) and returns one ACK/NAK/status byte per command.
//
//   Opcodes: 'D' 0x44 + 2 bytes (delay, MSB first) -> ACK
//            'R' 0x52 + 3 bytes (run length N, MSB first) -> ACK at end of run,
//                N=0 -> NAK; 'A' 0x41 during a run aborts it -> NAK
//            'S' 0x53 -> {6'b0, delay_loaded, last_nak}
//            anything else in IDLE (including 'A') -> NAK
//
//   Ports:
//     clk, n_reset           clock, asynchronous active-low reset
//     rx_data, rx_valid      received byte + one-cycle strobe
//     tx_data, tx_valid      response byte, held until tx_ready
//     tx_ready               transmitter accept
//     delay_len, delay_load  programmed delay length + one-cycle update pulse
//     run, out_en            run window / tristate drive enable (identical)
//
//   Optional: define HARNESS_SEQ_TIMEOUT_EN to discard a partial command (NAK)
//   after TIMEOUT cycles without an argument byte.

module harness_sequencer #(
  parameter int unsigned DELAY_W = 16,
  parameter int unsigned RUN_W   = 24,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [DELAY_W-1:0] delay_len,
  output logic               delay_load,
  output logic               run,
  output logic               out_en
);

  localparam logic [7:0] OP_D = 8'h44;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_S = 8'h53;
  localparam logic [7:0] OP_A = 8'h41;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [1:0] {IDLE, ARG, RUN, RESP} state_t;

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("harness_sequencer: TIMEOUT must be nonzero");
  end

  state_t           state;
  logic [15:0]      arg_sr;       // previously received argument bytes
  logic [1:0]       arg_left;     // argument bytes still expected
  logic             arg_is_d;
  logic [RUN_W-1:0] run_cnt;
  logic             delay_loaded;
  logic             last_nak;
  logic [23:0]      arg_full;
  logic [RUN_W-1:0] run_n;

`ifdef HARNESS_SEQ_TIMEOUT_EN
  logic [31:0]      idle_cnt;
`endif

  // Full argument as it stands once the current byte is appended.
  always_comb begin
    arg_full = {arg_sr, rx_data};
    run_n    = RUN_W'(arg_full);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      arg_sr       <= '0;
      arg_left     <= '0;
      arg_is_d     <= 1'b0;
      run_cnt      <= '0;
      delay_loaded <= 1'b0;
      last_nak     <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      delay_len    <= '0;
      delay_load   <= 1'b0;
      run          <= 1'b0;
      out_en       <= 1'b0;
`ifdef HARNESS_SEQ_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      delay_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
`ifdef HARNESS_SEQ_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            case (rx_data)
              OP_D: begin
                state    <= ARG;
                arg_left <= 2'd2;
                arg_is_d <= 1'b1;
              end
              OP_R: begin
                state    <= ARG;
                arg_left <= 2'd3;
                arg_is_d <= 1'b0;
              end
              OP_S: begin
                tx_data  <= {6'b0, delay_loaded, last_nak};
                tx_valid <= 1'b1;
                state    <= RESP;
              end
              default: begin
                tx_data  <= NAK;
                tx_valid <= 1'b1;
                last_nak <= 1'b1;
                state    <= RESP;
              end
            endcase
          end
        end

        ARG: begin
          if (rx_valid) begin
            arg_sr   <= {arg_sr[7:0], rx_data};
            arg_left <= arg_left - 2'd1;
`ifdef HARNESS_SEQ_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (arg_left == 2'd1) begin
              if (arg_is_d) begin
                delay_len    <= DELAY_W'(arg_full[15:0]);
                delay_load   <= 1'b1;
                delay_loaded <= 1'b1;
                tx_data      <= ACK;
                tx_valid     <= 1'b1;
                last_nak     <= 1'b0;
                state        <= RESP;
              end else if (run_n == '0) begin
                tx_data  <= NAK;
                tx_valid <= 1'b1;
                last_nak <= 1'b1;
                state    <= RESP;
              end else begin
                run_cnt <= run_n;
                run     <= 1'b1;
                out_en  <= 1'b1;
                state   <= RUN;
              end
            end
          end
`ifdef HARNESS_SEQ_TIMEOUT_EN
          else if (idle_cnt == 32'(TIMEOUT - 1)) begin
            tx_data  <= NAK;
            tx_valid <= 1'b1;
            last_nak <= 1'b1;
            state    <= RESP;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
`endif
        end

        // Completion is tested first so an abort on the final edge is dropped.
        RUN: begin
          if (run_cnt == RUN_W'(1)) begin
            run      <= 1'b0;
            out_en   <= 1'b0;
            tx_data  <= ACK;
            tx_valid <= 1'b1;
            last_nak <= 1'b0;
            state    <= RESP;
          end else if (rx_valid && rx_data == OP_A) begin
            run      <= 1'b0;
            out_en   <= 1'b0;
            tx_data  <= NAK;
            tx_valid <= 1'b1;
            last_nak <= 1'b1;
            state    <= RESP;
          end else begin
            run_cnt <= run_cnt - RUN_W'(1);
          end
        end

        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
